// File: rtl/tod_event_sequencer.sv
// Time-of-day event sequencer: once per second emits the seconds marker on the PPS edge,
// then shifts out the next seconds value MSB first, sharing the code slot with a user requester.
module tod_event_sequencer #(
    parameter int         NOMINAL_CLK_RATE      = 125_000_000,
    parameter int         SECONDS_WIDTH         = 32,
    parameter logic [7:0] EVCODE_SHIFT_ZERO     = 8'h70,
    parameter logic [7:0] EVCODE_SHIFT_ONE      = 8'h71,
    parameter logic [7:0] EVCODE_SECONDS_MARKER = 8'h7D,
    parameter int         SHIFT_START_DELAY     = 1000,
    parameter int         SHIFT_SPACING         = 8,
    parameter int         STATUS_COUNTER_WIDTH  = 10
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            pps,
    input  logic [SECONDS_WIDTH-1:0]        secondsSet,
    input  logic                            secondsSetStrobe,
    input  logic [7:0]                      userEvCode,
    input  logic                            userEvCodeValid,
    output logic                            userEvCodeReady,
    output logic [7:0]                      evCode,
    output logic                            evCodeValid,
    output logic [SECONDS_WIDTH-1:0]        seconds,
    output logic                            secondsValid,
    output logic                            ppsLost,
    output logic [STATUS_COUNTER_WIDTH-1:0] truncatedCounter,
    output logic [STATUS_COUNTER_WIDTH-1:0] reservedDropCounter
);

    localparam int WD_LIMIT = NOMINAL_CLK_RATE + NOMINAL_CLK_RATE / 50;
    localparam int WD_W     = $clog2(WD_LIMIT + 2);
    localparam int CNT_MAX  = (SHIFT_START_DELAY > SHIFT_SPACING) ? SHIFT_START_DELAY : SHIFT_SPACING;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int BIT_W    = $clog2(SECONDS_WIDTH);

    // Delay load is two short: one cycle spent leaving the marker, one entering SHIFT with the slot due.
    localparam logic [CNT_W-1:0] DELAY_LOAD   = CNT_W'(SHIFT_START_DELAY - 2);
    localparam logic [CNT_W-1:0] SPACING_LOAD = CNT_W'(SHIFT_SPACING - 1);
    localparam logic [BIT_W-1:0] BITS_LOAD    = BIT_W'(SECONDS_WIDTH - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT_V   = WD_W'(WD_LIMIT);
    localparam logic [WD_W-1:0]  WD_SAT       = WD_W'(WD_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [BIT_W-1:0]                bits_q, bits_d;
    logic [SECONDS_WIDTH-1:0]        secs_next_q, secs_next_d;
    logic                            pend_q, pend_d;
    logic [SECONDS_WIDTH-1:0]        pend_val_q, pend_val_d;
    logic                            pps_prev_q;
    logic [SECONDS_WIDTH-1:0]        seconds_q, seconds_d;
    logic                            secs_valid_q, secs_valid_d;
    logic [7:0]                      evcode_q, evcode_d;
    logic                            evcode_valid_q, evcode_valid_d;
    logic                            pps_lost_q, pps_lost_d;
    logic [STATUS_COUNTER_WIDTH-1:0] trunc_q, trunc_d;
    logic [STATUS_COUNTER_WIDTH-1:0] drop_q, drop_d;
    logic [WD_W-1:0]                 wd_cnt_q, wd_cnt_d;

    logic pps_edge, marker, slot_due, user_fire, user_rsvd, wd_expire;

    always_comb begin
        pps_edge        = pps && !pps_prev_q;
        marker          = enable && pps_edge;
        slot_due        = enable && (state_q == ST_SHIFT) && (cnt_q == '0);
        userEvCodeReady = !marker && !slot_due;
        user_fire       = userEvCodeValid && userEvCodeReady;
        user_rsvd       = (userEvCode == EVCODE_SHIFT_ZERO) || (userEvCode == EVCODE_SHIFT_ONE) ||
                          (userEvCode == EVCODE_SECONDS_MARKER);
        wd_expire       = (wd_cnt_q > WD_LIMIT_V) && !pps_edge;

        state_d        = state_q;
        cnt_d          = cnt_q;
        bits_d         = bits_q;
        secs_next_d    = secs_next_q;
        pend_d         = pend_q;
        pend_val_d     = pend_val_q;
        seconds_d      = seconds_q;
        secs_valid_d   = secs_valid_q;
        evcode_d       = evcode_q;
        evcode_valid_d = 1'b0;
        pps_lost_d     = pps_lost_q;
        trunc_d        = trunc_q;
        drop_d         = drop_q;
        wd_cnt_d       = wd_cnt_q;

        case (state_q)
            ST_DELAY: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = SPACING_LOAD;
                    if (bits_q == '0) state_d = ST_DONE;
                    else              bits_d  = bits_q - 1'b1;
                end
            end
            default: ;
        endcase

        if (marker) begin
            evcode_d       = EVCODE_SECONDS_MARKER;
            evcode_valid_d = 1'b1;
            if (state_q == ST_DONE) begin
                seconds_d    = secs_next_q;
                secs_valid_d = 1'b1;
            end else begin
                secs_valid_d = 1'b0;
            end
            if (((state_q == ST_DELAY) || (state_q == ST_SHIFT)) && (trunc_q != '1))
                trunc_d = trunc_q + 1'b1;
            secs_next_d = pend_q ? pend_val_q : secs_next_q + 1'b1;
            pend_d      = 1'b0;
            state_d     = ST_DELAY;
            cnt_d       = DELAY_LOAD;
            bits_d      = BITS_LOAD;
        end else if (slot_due) begin
            evcode_d       = secs_next_q[bits_q] ? EVCODE_SHIFT_ONE : EVCODE_SHIFT_ZERO;
            evcode_valid_d = 1'b1;
        end else if (user_fire) begin
            if (user_rsvd) begin
                if (drop_q != '1) drop_d = drop_q + 1'b1;
            end else begin
                evcode_d       = userEvCode;
                evcode_valid_d = 1'b1;
            end
        end

        // A strobe coinciding with a marker is kept for the following marker.
        if (secondsSetStrobe) begin
            pend_d     = 1'b1;
            pend_val_d = secondsSet;
        end

        if (!enable) begin
            state_d      = ST_IDLE;
            secs_valid_d = 1'b0;
        end

        if (pps_edge) begin
            wd_cnt_d   = WD_W'(1);
            pps_lost_d = 1'b0;
        end else if (wd_cnt_q != WD_SAT) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        // Dropping out of DONE makes the recovery marker report secondsValid=0.
        if (wd_expire) begin
            pps_lost_d   = 1'b1;
            secs_valid_d = 1'b0;
            state_d      = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            bits_q         <= '0;
            secs_next_q    <= '0;
            pend_q         <= 1'b0;
            pend_val_q     <= '0;
            pps_prev_q     <= 1'b0;
            seconds_q      <= '0;
            secs_valid_q   <= 1'b0;
            evcode_q       <= '0;
            evcode_valid_q <= 1'b0;
            pps_lost_q     <= 1'b0;
            trunc_q        <= '0;
            drop_q         <= '0;
            wd_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bits_q         <= bits_d;
            secs_next_q    <= secs_next_d;
            pend_q         <= pend_d;
            pend_val_q     <= pend_val_d;
            pps_prev_q     <= pps;
            seconds_q      <= seconds_d;
            secs_valid_q   <= secs_valid_d;
            evcode_q       <= evcode_d;
            evcode_valid_q <= evcode_valid_d;
            pps_lost_q     <= pps_lost_d;
            trunc_q        <= trunc_d;
            drop_q         <= drop_d;
            wd_cnt_q       <= wd_cnt_d;
        end
    end

    assign evCode              = evcode_q;
    assign evCodeValid         = evcode_valid_q;
    assign seconds             = seconds_q;
    assign secondsValid        = secs_valid_q;
    assign ppsLost             = pps_lost_q;
    assign truncatedCounter    = trunc_q;
    assign reservedDropCounter = drop_q;

endmodule

// File: tb/tb_tod_event_sequencer.sv
// Bench for tod_event_sequencer: user-path vector table, directed second/truncation/collision/
// watchdog/wrap/reset sequences and randomized traffic against a time-arithmetic reference model.
module tb_tod_event_sequencer;
    localparam int RATE  = 200;
    localparam int LIMIT = RATE + RATE / 50;
    localparam int D     = 20;
    localparam int S     = 4;
    localparam int W     = 32;
    localparam logic [7:0] ZERO = 8'h70;
    localparam logic [7:0] ONE  = 8'h71;
    localparam logic [7:0] MK   = 8'h7D;

    logic        clk, rst_n, enable, pps, secondsSetStrobe, userEvCodeValid;
    logic [31:0] secondsSet;
    logic [7:0]  userEvCode;
    logic        userEvCodeReady, evCodeValid, secondsValid, ppsLost;
    logic [7:0]  evCode;
    logic [31:0] seconds;
    logic [9:0]  truncatedCounter, reservedDropCounter;

    tod_event_sequencer #(
        .NOMINAL_CLK_RATE(RATE), .SECONDS_WIDTH(W), .SHIFT_START_DELAY(D), .SHIFT_SPACING(S)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pps(pps), .secondsSet(secondsSet),
        .secondsSetStrobe(secondsSetStrobe), .userEvCode(userEvCode),
        .userEvCodeValid(userEvCodeValid), .userEvCodeReady(userEvCodeReady), .evCode(evCode),
        .evCodeValid(evCodeValid), .seconds(seconds), .secondsValid(secondsValid),
        .ppsLost(ppsLost), .truncatedCounter(truncatedCounter),
        .reservedDropCounter(reservedDropCounter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0, n_cmp = 0, n_fail = 0;
    int t = 0;
    bit en_r = 0, rnd_ctl = 0;
    int umode = 0;
    bit last_ready;
    logic [31:0] cap;

    // Reference model: shift slots are derived from the marker time, not from counters.
    bit          m_pps_prev, m_active, m_complete, m_pending, m_svalid, m_lost, m_cvalid;
    logic [31:0] m_next, m_pval, m_seconds;
    logic [7:0]  m_code;
    int          m_start, m_last_edge, m_trunc, m_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
        end
    endtask

    task automatic model_reset();
        m_pps_prev = 0; m_active = 0; m_complete = 0; m_pending = 0; m_svalid = 0; m_lost = 0;
        m_cvalid = 0; m_next = 0; m_pval = 0; m_seconds = 0; m_code = 0;
        m_start = 0; m_trunc = 0; m_drop = 0; m_last_edge = t;
    endtask

    task automatic check_reset_vals();
        chk("rst_evCode", {24'h0, evCode}, 0);
        chk("rst_evCodeValid", {31'h0, evCodeValid}, 0);
        chk("rst_seconds", seconds, 0);
        chk("rst_secondsValid", {31'h0, secondsValid}, 0);
        chk("rst_ppsLost", {31'h0, ppsLost}, 0);
        chk("rst_trunc", {22'h0, truncatedCounter}, 0);
        chk("rst_drop", {22'h0, reservedDropCounter}, 0);
    endtask

    task automatic step(input bit en, input bit p, input bit strb, input logic [31:0] sv,
                        input bit uv, input logic [7:0] uc);
        bit edge_c, due, exp_ready;
        int el, idx;
        enable = en; pps = p; secondsSetStrobe = strb; secondsSet = sv;
        userEvCodeValid = uv; userEvCode = uc;
        edge_c = p && !m_pps_prev;
        due = 0; idx = 0;
        if (en && m_active && !m_complete) begin
            el = t - m_start - D;
            if (el >= 0 && (el % S) == 0 && (el / S) < W) begin due = 1; idx = el / S; end
        end
        exp_ready = !(en && edge_c) && !due;
        #1;
        last_ready = userEvCodeReady;
        chk("ready", {31'h0, userEvCodeReady}, {31'h0, exp_ready});
        m_cvalid = 0;
        if (en && edge_c) begin
            m_code = MK; m_cvalid = 1;
            if (m_active && m_complete) begin m_seconds = m_next; m_svalid = 1; end
            else m_svalid = 0;
            if (m_active && !m_complete && m_trunc < 1023) m_trunc++;
            m_next = m_pending ? m_pval : m_next + 1;
            m_pending = 0; m_active = 1; m_complete = 0; m_start = t;
        end else if (due) begin
            m_code = m_next[W-1-idx] ? ONE : ZERO; m_cvalid = 1;
            if (idx == W - 1) m_complete = 1;
        end else if (uv) begin
            if (uc == ZERO || uc == ONE || uc == MK) begin
                if (m_drop < 1023) m_drop++;
            end else begin
                m_code = uc; m_cvalid = 1;
            end
        end
        if (strb) begin m_pending = 1; m_pval = sv; end
        if (!en) begin m_active = 0; m_complete = 0; m_svalid = 0; end
        if (edge_c) begin m_lost = 0; m_last_edge = t; end
        else if (t - m_last_edge > LIMIT) begin
            m_lost = 1; m_active = 0; m_complete = 0; m_svalid = 0;
        end
        m_pps_prev = p;
        @(posedge clk);
        #1;
        t++;
        n_vec++;
        chk("evCodeValid", {31'h0, evCodeValid}, {31'h0, m_cvalid});
        if (m_cvalid) chk("evCode", {24'h0, evCode}, {24'h0, m_code});
        chk("seconds", seconds, m_seconds);
        chk("secondsValid", {31'h0, secondsValid}, {31'h0, m_svalid});
        chk("ppsLost", {31'h0, ppsLost}, {31'h0, m_lost});
        chk("truncatedCounter", {22'h0, truncatedCounter}, m_trunc);
        chk("reservedDropCounter", {22'h0, reservedDropCounter}, m_drop);
        if (evCodeValid && (evCode == ZERO || evCode == ONE)) cap = {cap[30:0], evCode == ONE};
    endtask

    task automatic drive(input bit p);
        bit uv, strb;
        logic [7:0] uc;
        logic [31:0] sv;
        uv = 0; uc = 0; strb = 0; sv = 0;
        if (umode == 1) begin
            uv = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 7))
                0: uc = MK;
                1: uc = ZERO;
                2: uc = ONE;
                default: uc = 8'($urandom_range(0, 255));
            endcase
        end else if (umode == 2) begin
            uv = 1; uc = 8'($urandom_range(0, 8'h6F));
        end
        if (rnd_ctl) begin
            if ($urandom_range(0, 49) == 0) begin strb = 1; sv = $urandom; end
            if ($urandom_range(0, 299) == 0) en_r = !en_r;
        end
        step(en_r, p, strb, sv, uv, uc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0);
    endtask

    // Next call's PPS edge lands exactly len cycles after this one's.
    task automatic edge_then(input int len);
        drive(1'b1);
        drive(1'b1);
        idle(len - 2);
    endtask

    typedef struct {
        bit         uv;
        logic [7:0] uc;
        bit         e_rdy;
        bit         e_v;
        logic [7:0] e_code;
        int         e_drop;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 8'h42, 1, 1, 8'h42, 0};
        tbl[1] = '{1, 8'h7D, 1, 0, 8'h00, 1};
        tbl[2] = '{1, 8'h42, 1, 1, 8'h42, 1};
        tbl[3] = '{0, 8'h55, 1, 0, 8'h00, 1};
        tbl[4] = '{1, 8'h70, 1, 0, 8'h00, 2};
        tbl[5] = '{1, 8'h71, 1, 0, 8'h00, 3};
        tbl[6] = '{1, 8'hFF, 1, 1, 8'hFF, 3};
        tbl[7] = '{1, 8'h00, 1, 1, 8'h00, 3};
        tbl[8] = '{1, 8'h7C, 1, 1, 8'h7C, 3};
        tbl[9] = '{1, 8'h7E, 1, 1, 8'h7E, 3};

        rst_n = 0; enable = 0; pps = 0; secondsSet = 0; secondsSetStrobe = 0;
        userEvCode = 0; userEvCodeValid = 0; cap = 0;
        #2;
        check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();

        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, tbl[i].uv, tbl[i].uc);
            chk("tbl_ready", {31'h0, last_ready}, {31'h0, tbl[i].e_rdy});
            chk("tbl_valid", {31'h0, evCodeValid}, {31'h0, tbl[i].e_v});
            if (tbl[i].e_v) chk("tbl_code", {24'h0, evCode}, {24'h0, tbl[i].e_code});
            chk("tbl_drop", {22'h0, reservedDropCounter}, tbl[i].e_drop);
        end

        en_r = 1;
        step(1, 0, 1, 32'h5, 0, 0);
        cap = 0;
        edge_then(RATE);
        chk("shift_5", cap, 32'h5);
        cap = 0;
        edge_then(RATE);
        chk("sec_after_2nd", seconds, 32'h5);
        chk("secv_after_2nd", {31'h0, secondsValid}, 1);
        chk("shift_6", cap, 32'h6);

        edge_then(D + 21 * S - 1);
        edge_then(10);
        chk("trunc_once", {22'h0, truncatedCounter}, 1);
        chk("trunc_secv", {31'h0, secondsValid}, 0);
        idle(RATE - 10);

        umode = 2;
        edge_then(D + 5 * S);
        edge_then(RATE);
        chk("collide_trunc", {22'h0, truncatedCounter}, 2);
        umode = 1;

        edge_then(RATE);
        edge_then(LIMIT + 1);
        chk("wd_not_yet", {31'h0, ppsLost}, 0);
        chk("wd_secv_before", {31'h0, secondsValid}, 1);
        idle(1);
        chk("wd_lost", {31'h0, ppsLost}, 1);
        chk("wd_secv", {31'h0, secondsValid}, 0);
        idle(5);
        edge_then(5);
        chk("wd_cleared", {31'h0, ppsLost}, 0);
        chk("wd_recov_secv", {31'h0, secondsValid}, 0);
        idle(RATE - 5);

        rnd_ctl = 1;
        for (int k = 0; k < 14; k++) edge_then($urandom_range(30, 210));
        rnd_ctl = 0;
        en_r = 1;
        edge_then(RATE);

        step(1, 0, 1, 32'hFFFF_FFFF, 0, 0);
        edge_then(RATE);
        chk("shift_ffff", cap, 32'hFFFF_FFFF);
        edge_then(D + 10 * S);
        chk("shift_wrap0", cap, 32'hFFFF_FC00);

        #2;
        rst_n = 0;
        #1;
        check_reset_vals();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_vals();
        rst_n = 1;
        model_reset();
        cap = 0;
        edge_then(RATE);
        chk("post_rst_shift", cap, 32'h1);
        chk("post_rst_secv", {31'h0, secondsValid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
